// File: rtl/i_cache.sv
// Direct-mapped instruction cache with a blocking line fill.
// Hits return combinationally in IDLE; misses fetch the whole line one word per mem_ack.
module i_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 i_flush,
  output logic                 mem_read,
  output logic [WORD_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ack,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]     fill_idx_q, fill_idx_d;
  logic [OFF_W-1:0]     fill_cnt_q, fill_cnt_d;
  logic [15:0]          hit_cnt_q, hit_cnt_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             hit;
  logic             fill_word;
  logic             fill_last;

  assign req_tag = i_address[WORD_SIZE-1 -: TAG_W];
  assign req_idx = i_address[OFF_W +: IDX_W];
  assign req_off = i_address[OFF_W-1:0];

  assign hit       = (state_q == IDLE) && i_read && valid_q[req_idx]
                     && (tag_q[req_idx] == req_tag);
  assign fill_word = (state_q == FILL) && mem_ack;
  assign fill_last = fill_word && (fill_cnt_q == OFF_W'(LINE_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    fill_cnt_d = fill_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          hit_cnt_d = hit_cnt_q + 16'd1;
        end else if (i_read) begin
          state_d    = FILL;
          fill_tag_d = req_tag;
          fill_idx_d = req_idx;
          fill_cnt_d = '0;
          miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_cnt_d = fill_cnt_q + OFF_W'(1);
          if (fill_last) begin
            state_d             = IDLE;
            valid_d[fill_idx_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides a line completing on the same edge.
    if (i_flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      fill_cnt_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      fill_cnt_q <= fill_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_word) data_q[{fill_idx_q, fill_cnt_q}] <= mem_data;
    if (fill_last) tag_q[fill_idx_q] <= fill_tag_q;
  end

  assign i_ready     = hit;
  assign i_data      = hit ? data_q[{req_idx, req_off}] : '0;
  assign mem_read    = (state_q == FILL);
  assign mem_address = mem_read ? {fill_tag_q, fill_idx_q, fill_cnt_q} : '0;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule
